// File: rtl/evict_buffer.sv
// Write-back eviction FIFO between L1 and pmem, with combinational youngest-match lookup; optional EVICT_BUFFER_MERGE_EN.
// Latency: accepted line visible next cycle, drain request at earliest one edge later; lookup is zero-cycle.
// Backpressure: evict_ready drops when full (unless a merge target exists); drain waits on drain_inhibit and pmem_resp.
module evict_buffer #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         evict_valid,
    input  logic [11:0]  evict_tag,
    input  logic [127:0] evict_data,
    output logic         evict_ready,
    input  logic [11:0]  lookup_tag,
    output logic         lookup_hit,
    output logic [127:0] lookup_data,
    input  logic         drain_inhibit,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic         pmem_resp,
    output logic         empty,
    output logic         full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t          state_q, state_d;
    logic [11:0]     tag_q  [DEPTH];
    logic [127:0]    data_q [DEPTH];
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q;
    logic            merge_match;
    logic            accept, push, pop;

    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(DEPTH));
    assign evict_ready = !full || merge_match;
    assign accept      = evict_valid && evict_ready;
    assign push        = accept && !merge_match;
    assign pop         = (state_q == WRITE) && pmem_resp;

`ifdef EVICT_BUFFER_MERGE_EN
    logic [PW-1:0] merge_idx;
    logic [PW-1:0] mg_idx;

    // The head being written is frozen; a matching eviction must queue behind it.
    always_comb begin
        merge_match = 1'b0;
        merge_idx   = '0;
        mg_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            mg_idx = head_q + PW'(k);
            if (CW'(k) < count_q && tag_q[mg_idx] == evict_tag &&
                !(k == 0 && state_q == WRITE)) begin
                merge_match = 1'b1;
                merge_idx   = mg_idx;
            end
        end
    end
`else
    assign merge_match = 1'b0;
`endif

    // Walk oldest to youngest so the youngest match is the one left standing.
    logic [PW-1:0] lk_idx;
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        lk_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            lk_idx = head_q + PW'(k);
            if (CW'(k) < count_q && tag_q[lk_idx] == lookup_tag) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[lk_idx];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pmem_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !drain_inhibit) state_d = WRITE;
            end
            WRITE: begin
                pmem_write = 1'b1;
                if (pmem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pmem_address = (state_q == WRITE) ? {tag_q[head_q], 4'b0000} : '0;
    assign pmem_wdata   = (state_q == WRITE) ? data_q[head_q] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (pop)  head_q <= head_q + PW'(1);
            if (push) tail_q <= tail_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset: validity is carried entirely by count/head.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[tail_q]  <= evict_tag;
            data_q[tail_q] <= evict_data;
        end
`ifdef EVICT_BUFFER_MERGE_EN
        else if (accept && merge_match) begin
            data_q[merge_idx] <= evict_data;
        end
`endif
    end

endmodule

// File: tb/tb_evict_buffer.sv
// Bench for evict_buffer: directed scenarios plus random traffic against a queue-based reference model.
module tb_evict_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         evict_valid;
    logic [11:0]  evict_tag;
    logic [127:0] evict_data;
    logic         evict_ready;
    logic [11:0]  lookup_tag;
    logic         lookup_hit;
    logic [127:0] lookup_data;
    logic         drain_inhibit;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic         empty;
    logic         full;

    evict_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .evict_valid(evict_valid), .evict_tag(evict_tag), .evict_data(evict_data),
        .evict_ready(evict_ready),
        .lookup_tag(lookup_tag), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .drain_inhibit(drain_inhibit),
        .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0]  tag;
        logic [127:0] data;
    } ent_t;

    ent_t q[$];
    bit   writing;
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [127:0] DA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [127:0] DB = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
    localparam logic [127:0] DC = 128'hCCCC_0001_CCCC_0002_CCCC_0003_CCCC_0004;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs mid-cycle, then advance the model at the edge.
    task automatic step(input logic v, input logic [11:0] t, input logic [127:0] d,
                        input logic [11:0] lt, input logic inh, input logic rsp);
        bit           e_hit, e_ready, fire, pop, start;
        logic [127:0] e_ld;
        int           mi;
        evict_valid   = v;
        evict_tag     = t;
        evict_data    = d;
        lookup_tag    = lt;
        drain_inhibit = inh;
        pmem_resp     = rsp;
        @(negedge clk);
        e_hit = 0;
        e_ld  = '0;
        foreach (q[i]) if (q[i].tag == lt) begin e_hit = 1; e_ld = q[i].data; end
        mi = -1;
`ifdef EVICT_BUFFER_MERGE_EN
        foreach (q[i]) if (q[i].tag == t && !(i == 0 && writing)) mi = i;
`endif
        e_ready = (q.size() < 4) || (mi >= 0);
        check("empty", 128'(empty), 128'(q.size() == 0));
        check("full", 128'(full), 128'(q.size() == 4));
        check("evict_ready", 128'(evict_ready), 128'(e_ready));
        check("lookup_hit", 128'(lookup_hit), 128'(e_hit));
        check("lookup_data", lookup_data, e_ld);
        check("pmem_write", 128'(pmem_write), 128'(writing));
        check("pmem_address", 128'(pmem_address), writing ? 128'({q[0].tag, 4'h0}) : 128'(0));
        check("pmem_wdata", pmem_wdata, writing ? q[0].data : 128'(0));
        @(posedge clk);
        fire  = v && e_ready;
        pop   = writing && rsp;
        start = !writing && q.size() != 0 && !inh;
        if (fire && mi >= 0) q[mi].data = d;
        if (pop) void'(q.pop_front());
        if (fire && mi < 0) q.push_back('{tag: t, data: d});
        writing = writing ? !rsp : start;
        #1;
    endtask

    task automatic idle(input int n, input logic inh, input logic rsp);
        for (int i = 0; i < n; i++) step(1'b0, 12'h000, '0, 12'h123, inh, rsp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        writing = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] pool [4];
        logic [11:0] rt;
        pool[0] = 12'h055; pool[1] = 12'h123; pool[2] = 12'h010; pool[3] = 12'h020;
        rst_n = 1'b0; evict_valid = 0; evict_tag = '0; evict_data = '0;
        lookup_tag = 12'h000; drain_inhibit = 0; pmem_resp = 0;
        writing = 0;
        #2;
        check("rst_pmem_write", 128'(pmem_write), 128'(0));
        check("rst_evict_ready", 128'(evict_ready), 128'(1));
        check("rst_empty", 128'(empty), 128'(1));
        check("rst_full", 128'(full), 128'(0));
        check("rst_lookup_hit", 128'(lookup_hit), 128'(0));
        check("rst_lookup_data", lookup_data, 128'(0));
        check("rst_pmem_address", 128'(pmem_address), 128'(0));
        check("rst_pmem_wdata", pmem_wdata, 128'(0));
        do_reset();

        // Single line drain with a 3-cycle downstream latency.
        step(1'b1, 12'h123, DA, 12'h123, 1'b0, 1'b0);
        idle(4, 1'b0, 1'b0);
        check("drain_addr_seen", 128'(pmem_address), 128'h1230);
        step(1'b0, 12'h000, '0, 12'h123, 1'b0, 1'b1);
        idle(2, 1'b0, 1'b0);

        // Fill under inhibit, try one more (refused), then drain in order.
        for (int i = 0; i < 5; i++) step(1'b1, 12'h200 + 12'(i), DA ^ 128'(i), 12'h201, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(2, 1'b0, 1'b0);
            check("fifo_order", 128'(pmem_address), 128'({12'h200 + 12'(i), 4'h0}));
            step(1'b0, 12'h000, '0, 12'h203, 1'b0, 1'b1);
        end
        idle(2, 1'b0, 1'b0);

        // Same tag pushed again while the first copy is in WRITE.
        step(1'b1, 12'h055, DA, 12'h055, 1'b0, 1'b0);
        step(1'b0, 12'h000, '0, 12'h055, 1'b0, 1'b0);
        step(1'b1, 12'h055, DB, 12'h055, 1'b0, 1'b0);
        idle(2, 1'b0, 1'b0);
        step(1'b0, 12'h000, '0, 12'h055, 1'b0, 1'b1);
        idle(3, 1'b0, 1'b0);
        step(1'b0, 12'h000, '0, 12'h055, 1'b0, 1'b1);
        idle(2, 1'b0, 1'b0);

        // Merge-style sequence (pushes duplicates when merging is off).
        step(1'b1, 12'h010, DA, 12'h010, 1'b1, 1'b0);
        step(1'b1, 12'h020, DB, 12'h010, 1'b1, 1'b0);
        step(1'b1, 12'h010, DC, 12'h010, 1'b1, 1'b0);
        step(1'b0, 12'h000, '0, 12'h010, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(2, 1'b0, 1'b0);
            step(1'b0, 12'h000, '0, 12'h020, 1'b0, 1'b1);
        end
        idle(2, 1'b0, 1'b0);

        // Full in WRITE: response and eviction on the same edge.
        for (int i = 0; i < 4; i++) step(1'b1, 12'h300 + 12'(i), DB ^ 128'(i), 12'h300, 1'b1, 1'b0);
        idle(1, 1'b0, 1'b0);
        step(1'b1, 12'h3AA, DC, 12'h3AA, 1'b0, 1'b1);
        step(1'b1, 12'h3AA, DC, 12'h3AA, 1'b0, 1'b0);
        step(1'b0, 12'h000, '0, 12'h3AA, 1'b0, 1'b0);
        check("refill_full", 128'(full), 128'(1));

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            rt = ($urandom_range(0, 7) == 0) ? 12'($urandom) : pool[$urandom_range(0, 3)];
            step(1'($urandom_range(0, 1)), rt,
                 {$urandom, $urandom, $urandom, $urandom},
                 pool[$urandom_range(0, 3)],
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end

        // Asynchronous reset in the middle of a write.
        do_reset();
        step(1'b1, 12'h123, DA, 12'h123, 1'b0, 1'b0);
        step(1'b1, 12'h055, DB, 12'h123, 1'b0, 1'b0);
        idle(1, 1'b0, 1'b0);
        check("pre_rst_write", 128'(pmem_write), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_write", 128'(pmem_write), 128'(0));
        check("async_rst_empty", 128'(empty), 128'(1));
        q.delete();
        writing = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) step(1'b0, 12'h000, '0, pool[i], 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/evict_buffer.md
# evict_buffer

Write-back eviction buffer between the L1 data cache and the L2/physical-memory port. It accepts dirty 128-bit lines evicted by the L1 controller, holds up to DEPTH of them in a FIFO, and drains them one at a time to the downstream port with a request/response handshake. It also provides a combinational lookup so that an L1 refill can be served from a pending eviction rather than stale memory.

## Interface
- DEPTH, 4, number of line entries; power of two, 2..8
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- evict_valid  in  1  L1 presents an evicted line this cycle
- evict_tag  in  12  line address bits [15:4] (lc3b_evict_tag)
- evict_data  in  128  line data (lc3b_data)
- evict_ready  out  1  buffer can accept; a transfer occurs on an edge where evict_valid && evict_ready
- lookup_tag  in  12  line address probed by the L1 refill path
- lookup_hit  out  1  a buffered entry matches lookup_tag
- lookup_data  out  128  data of the youngest matching entry; 0 when no hit
- drain_inhibit  in  1  downstream read in progress; do not start a new write
- pmem_write  out  1  write request to downstream
- pmem_address  out  16  {head tag, 4'b0000}
- pmem_wdata  out  128  head entry data
- pmem_resp  in  1  downstream write complete
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- Storage: circular FIFO of {tag, data}; head pointer, tail pointer, count register of width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
- FSM states: IDLE, WRITE.
  - IDLE -> WRITE when !empty && !drain_inhibit.
  - WRITE: pmem_write=1, address/wdata driven from head; held stable until pmem_resp.
  - WRITE -> IDLE on pmem_resp; head entry popped on the same edge.
  - drain_inhibit is ignored once in WRITE.
- evict_ready = !full, computed from registered count, or, with merging enabled, an eligible tag match exists (see Configuration).
- Push: on accepted transfer, entry written at tail, tail++, count++.
- Simultaneous push and pop: both occur, count unchanged; allowed only when !full before the edge.
- Lookup: combinational compare against all valid entries, including the head while it is in WRITE; on multiple matches the youngest entry (closest to tail) wins.
- pmem_resp outside WRITE is ignored.
- Reset values: state IDLE, count 0, pointers 0, pmem_write 0, evict_ready 1, empty 1, full 0, lookup_hit 0, lookup_data 0, pmem_address 0, pmem_wdata 0.
- Reset asserted mid-write: pmem_write drops immediately (asynchronous); all buffered lines are discarded.

## Timing
- Accepted at edge N -> visible to lookup and empty/full in the cycle after edge N.
- Minimum drain latency: accept at edge N; IDLE->WRITE at edge N+1; pmem_write high from N+1 until the edge sampling pmem_resp.
- Every drain is followed by at least one IDLE cycle. Throughput is 1 line per (downstream latency + 2) cycles.
- Lookup is combinational: zero-cycle latency from lookup_tag to lookup_hit/lookup_data.

## Configuration
- EVICT_BUFFER_MERGE_EN defined: an accepted eviction whose tag matches a buffered entry that is not the head in WRITE overwrites that entry's data in place; there is no push and count is unchanged. The merge is accepted even when full. evict_ready = !full || merge_match.
- Undefined: every accepted eviction pushes a new entry; evict_ready = !full; duplicate tags may coexist, and the youngest-wins rule resolves lookups.

## Test plan
- Reset, then push tag 0x123 with data A -> next cycle empty=0; at the following edge pmem_write=1 and pmem_address=0x1230; drive pmem_resp after 3 cycles -> pmem_write=0 and empty=1.
- Hold drain_inhibit=1 and push DEPTH=4 lines -> full=1, evict_ready=0, pmem_write stays 0; release drain_inhibit -> lines drain in FIFO order.
- Push tag 0x055 (data A), then tag 0x055 (data B) while the first entry is in WRITE -> pmem_wdata stays A; lookup 0x055 returns B; second write carries B.
- With EVICT_BUFFER_MERGE_EN and inhibit held, push 0x010/A, 0x020/B, 0x010/C -> count=2; lookup 0x010 = C; drained order 0x0100/C, 0x0200/B.
- Full buffer in WRITE; pmem_resp and evict_valid arrive on the same edge -> pop only, no push; the new line is accepted on the next edge and count returns to 4.
- Assert rst_n=0 during WRITE -> pmem_write goes to 0 asynchronously; after release empty=1 and lookup_hit=0 for all tags.
